// File: rtl/cache_line_fill_pkg.sv
// Shared cache geometry, derived fill constants and the fill FSM state type.
package cache_line_fill_pkg;

  localparam int NUM_WAYS         = 4;
  localparam int NUM_SETS         = 16;
  localparam int CACHE_LINE_BYTES = 64;
  localparam int BUS_DATA_BITS    = 32;
  localparam int ADDR_WIDTH       = 32;

  localparam int NUM_WAYS_LOG    = $clog2(NUM_WAYS);
  localparam int NUM_SETS_LOG    = $clog2(NUM_SETS);
  localparam int CACHE_LINE_BITS = CACHE_LINE_BYTES * 8;
  localparam int OFFSET_BITS     = $clog2(CACHE_LINE_BYTES);
  localparam int NUM_BEATS       = CACHE_LINE_BITS / BUS_DATA_BITS;
  localparam int BEAT_CNT_BITS   = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    FILL    = 2'd2,
    WRITE   = 2'd3
  } fill_state_e;

  // Clears the byte-offset bits so the address names the whole line.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'(CACHE_LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/cache_line_fill_if.sv
// Fill request, memory burst read and data-array write port of the line fill engine.
interface cache_line_fill_if;
  import cache_line_fill_pkg::*;

  logic                       fill_req_valid;
  logic                       fill_req_ready;
  logic [ADDR_WIDTH-1:0]      fill_req_addr;
  logic [NUM_WAYS_LOG-1:0]    fill_req_way_idx;
  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic [ADDR_WIDTH-1:0]      mem_req_addr;
  logic                       mem_rsp_valid;
  logic                       mem_rsp_ready;
  logic [BUS_DATA_BITS-1:0]   mem_rsp_data;
  logic                       update_en;
  logic [NUM_WAYS_LOG-1:0]    update_way_idx;
  logic [NUM_SETS_LOG-1:0]    update_set_idx;
  logic [CACHE_LINE_BITS-1:0] update_data;
  logic                       fill_done_valid;
  logic [ADDR_WIDTH-1:0]      fill_done_addr;

  // The fill engine's own view.
  modport slave (
    input  fill_req_valid, fill_req_addr, fill_req_way_idx,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output fill_req_ready, mem_req_valid, mem_req_addr, mem_rsp_ready,
           update_en, update_way_idx, update_set_idx, update_data,
           fill_done_valid, fill_done_addr
  );

  // The surrounding miss controller / memory / data array view.
  modport master (
    output fill_req_valid, fill_req_addr, fill_req_way_idx,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  fill_req_ready, mem_req_valid, mem_req_addr, mem_rsp_ready,
           update_en, update_way_idx, update_set_idx, update_data,
           fill_done_valid, fill_done_addr
  );

endinterface

// File: rtl/cache_line_fill_dffs.sv
// General flop library: plain and load-enabled flops, async active-low reset to zero.
module sirv_gnrl_dffr #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qout <= '0;
    else        qout <= dnxt;
  end

endmodule

module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    qout <= '0;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/cache_line_fill.sv
// Line fill engine: one burst read per miss, beats assembled into a line,
// then a single-cycle write into the selected way of the cache data array.
module cache_line_fill
  import cache_line_fill_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  cache_line_fill_if.slave bus
);

  fill_state_e                w_state;
  fill_state_e                w_state_nxt;
  logic [1:0]                 r_state;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [ADDR_WIDTH-1:0]      w_addr_aligned;
  logic [NUM_WAYS_LOG-1:0]    r_way;
  logic [BEAT_CNT_BITS-1:0]   r_beat_cnt;
  logic [BEAT_CNT_BITS-1:0]   w_beat_cnt_nxt;
  logic [CACHE_LINE_BITS-1:0] r_line;
  logic [CACHE_LINE_BITS-1:0] w_line_nxt;
  logic                       w_req_acc;
  logic                       w_mem_hs;
  logic                       w_beat_acc;
  logic                       w_cnt_ld;

  assign w_state    = fill_state_e'(r_state);
  assign w_req_acc  = (w_state == IDLE)    && bus.fill_req_valid;
  assign w_mem_hs   = (w_state == MEM_REQ) && bus.mem_req_ready;
  assign w_beat_acc = (w_state == FILL)    && bus.mem_rsp_valid;

  sirv_gnrl_dffr #(.DW(2)) u_state_dff (
    .dnxt(w_state_nxt), .qout(r_state), .clk(clk), .rst_n(rst_n)
  );

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      IDLE:    if (bus.fill_req_valid) w_state_nxt = MEM_REQ;
      MEM_REQ: if (bus.mem_req_ready)  w_state_nxt = FILL;
      FILL:    if (bus.mem_rsp_valid && (r_beat_cnt == BEAT_CNT_BITS'(NUM_BEATS - 1)))
                 w_state_nxt = WRITE;
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.fill_req_ready  = 1'b0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_rsp_ready   = 1'b0;
    bus.update_en       = 1'b0;
    bus.fill_done_valid = 1'b0;
    case (w_state)
      IDLE:    bus.fill_req_ready = 1'b1;
      MEM_REQ: bus.mem_req_valid  = 1'b1;
      FILL:    bus.mem_rsp_ready  = 1'b1;
      WRITE: begin
        bus.update_en       = 1'b1;
        bus.fill_done_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_addr_aligned = line_align(bus.fill_req_addr);

  sirv_gnrl_dfflr #(.DW(ADDR_WIDTH)) u_addr_dff (
    .lden(w_req_acc), .dnxt(w_addr_aligned), .qout(r_addr), .clk(clk), .rst_n(rst_n)
  );

  sirv_gnrl_dfflr #(.DW(NUM_WAYS_LOG)) u_way_dff (
    .lden(w_req_acc), .dnxt(bus.fill_req_way_idx), .qout(r_way), .clk(clk), .rst_n(rst_n)
  );

  // The memory handshake restarts the count; the final beat wraps it back to zero.
  assign w_cnt_ld       = w_mem_hs | w_beat_acc;
  assign w_beat_cnt_nxt = w_mem_hs ? '0 : r_beat_cnt + 1'b1;

  sirv_gnrl_dfflr #(.DW(BEAT_CNT_BITS)) u_cnt_dff (
    .lden(w_cnt_ld), .dnxt(w_beat_cnt_nxt), .qout(r_beat_cnt), .clk(clk), .rst_n(rst_n)
  );

  always_comb begin
    w_line_nxt = r_line;
    w_line_nxt[int'(r_beat_cnt) * BUS_DATA_BITS +: BUS_DATA_BITS] = bus.mem_rsp_data;
  end

  sirv_gnrl_dfflr #(.DW(CACHE_LINE_BITS)) u_line_dff (
    .lden(w_beat_acc), .dnxt(w_line_nxt), .qout(r_line), .clk(clk), .rst_n(rst_n)
  );

  assign bus.mem_req_addr   = r_addr;
  assign bus.fill_done_addr = r_addr;
  assign bus.update_way_idx = r_way;
  assign bus.update_set_idx = r_addr[OFFSET_BITS +: NUM_SETS_LOG];
  assign bus.update_data    = r_line;

endmodule

// File: tb/tb_cache_line_fill.sv
// Randomized scoreboard bench for cache_line_fill: the stimulus side predicts each
// completed fill from address arithmetic; a negedge monitor checks every update pulse.
module tb_cache_line_fill;
  import cache_line_fill_pkg::*;

  typedef logic [CACHE_LINE_BITS-1:0] vec_t;

  typedef struct {
    vec_t                    data;
    logic [NUM_WAYS_LOG-1:0] way;
    logic [NUM_SETS_LOG-1:0] set;
    logic [ADDR_WIDTH-1:0]   addr;
    int                      expEdge;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cache_line_fill_if bus ();

  cache_line_fill dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks       = 0;
  int   failures     = 0;
  int   edgeCnt      = 0;
  int   lastBeatEdge = 0;
  bit   heldPrev     = 1'b0;
  bit   prevUpdate   = 1'b0;
  vec_t lastLine     = '0;
  exp_t sbQ[$];

  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input vec_t actual, input vec_t required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Scoreboard monitor: every update pulse must match the oldest predicted fill.
  always @(negedge clk) begin
    exp_t e;
    if (prevUpdate) checkOutput("update_pulse_width", vec_t'(bus.update_en), vec_t'(0));
    if (bus.update_en === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_update", vec_t'(1), vec_t'(0));
      end else begin
        e = sbQ.pop_front();
        checkOutput("update_data", bus.update_data, e.data);
        checkOutput("update_way_idx", vec_t'(bus.update_way_idx), vec_t'(e.way));
        checkOutput("update_set_idx", vec_t'(bus.update_set_idx), vec_t'(e.set));
        checkOutput("fill_done_addr", vec_t'(bus.fill_done_addr), vec_t'(e.addr));
        checkOutput("fill_done_valid", vec_t'(bus.fill_done_valid), vec_t'(1));
        if (e.expEdge >= 0) checkOutput("update_latency", vec_t'(edgeCnt), vec_t'(e.expEdge));
      end
    end
    prevUpdate = (bus.update_en === 1'b1);
  end

  // One fill transaction; abortAfter >= 0 pulses reset after that beat index.
  task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] addr, input int way,
                               input int reqDelay, input int maxGap, input bit patterned,
                               input bit holdReq, input int abortAfter, input bit checkLatency);
    vec_t                    line;
    logic [ADDR_WIDTH-1:0]   aligned;
    logic [BUS_DATA_BITS-1:0] beat;
    int                      tAcc;
    int                      waitCnt;
    int                      gap;
    exp_t                    e;
    line    = '0;
    aligned = addr - ADDR_WIDTH'(addr % CACHE_LINE_BYTES);
    bus.fill_req_valid   = 1'b1;
    bus.fill_req_addr    = addr;
    bus.fill_req_way_idx = NUM_WAYS_LOG'(way);
    waitCnt = 0;
    while (bus.fill_req_ready !== 1'b1 && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt >= 50) begin
      checkOutput("req_ready_timeout", vec_t'(0), vec_t'(1));
      bus.fill_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    tAcc = edgeCnt;
    if (!holdReq) bus.fill_req_valid = 1'b0;
    if (heldPrev) checkOutput("held_req_accept_edge", vec_t'(tAcc), vec_t'(lastBeatEdge + 2));
    checkOutput("fill_req_ready_busy", vec_t'(bus.fill_req_ready), vec_t'(0));
    for (int i = 0; i < reqDelay; i++) begin
      checkOutput("mem_req_valid_stall", vec_t'(bus.mem_req_valid), vec_t'(1));
      checkOutput("mem_req_addr_stall", vec_t'(bus.mem_req_addr), vec_t'(aligned));
      @(posedge clk); #1;
    end
    checkOutput("mem_req_valid", vec_t'(bus.mem_req_valid), vec_t'(1));
    checkOutput("mem_req_addr", vec_t'(bus.mem_req_addr), vec_t'(aligned));
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    checkOutput("mem_req_valid_drop", vec_t'(bus.mem_req_valid), vec_t'(0));
    for (int n = 0; n < NUM_BEATS; n++) begin
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      repeat (gap) begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = $urandom;
        @(posedge clk); #1;
      end
      beat = patterned ? (32'h1000_0000 + 32'(n)) : $urandom;
      line[n * BUS_DATA_BITS +: BUS_DATA_BITS] = beat;
      checkOutput("mem_rsp_ready", vec_t'(bus.mem_rsp_ready), vec_t'(1));
      if (holdReq) checkOutput("ready_while_held", vec_t'(bus.fill_req_ready), vec_t'(0));
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = beat;
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      if (n == abortAfter) begin
        rst_n = 1'b0;
        #2;
        checkOutput("abort_fill_req_ready", vec_t'(bus.fill_req_ready), vec_t'(1));
        checkOutput("abort_mem_rsp_ready", vec_t'(bus.mem_rsp_ready), vec_t'(0));
        checkOutput("abort_line_cleared", bus.update_data, vec_t'(0));
        @(posedge clk); #1;
        rst_n    = 1'b1;
        heldPrev = 1'b0;
        lastLine = '0;
        repeat (NUM_BEATS + 4) @(posedge clk);
        #1;
        checkOutput("post_abort_line", bus.update_data, vec_t'(0));
        return;
      end
    end
    lastBeatEdge = edgeCnt;
    checkOutput("mem_rsp_ready_write", vec_t'(bus.mem_rsp_ready), vec_t'(0));
    checkOutput("fill_req_ready_write", vec_t'(bus.fill_req_ready), vec_t'(0));
    e.data    = line;
    e.way     = NUM_WAYS_LOG'(way);
    e.set     = NUM_SETS_LOG'((aligned / CACHE_LINE_BYTES) % NUM_SETS);
    e.addr    = aligned;
    e.expEdge = checkLatency ? (tAcc + NUM_BEATS + 1) : -1;
    sbQ.push_back(e);
    lastLine = line;
    heldPrev = holdReq;
  endtask

  // Beats offered while idle must be refused and leave the line buffer alone.
  task automatic idleBeats();
    @(posedge clk); #1;
    repeat (4) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = $urandom;
      checkOutput("idle_mem_rsp_ready", vec_t'(bus.mem_rsp_ready), vec_t'(0));
      @(posedge clk); #1;
    end
    bus.mem_rsp_valid = 1'b0;
    checkOutput("idle_line_unchanged", bus.update_data, lastLine);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    bus.fill_req_valid   = 1'b0;
    bus.fill_req_addr    = '0;
    bus.fill_req_way_idx = '0;
    bus.mem_req_ready    = 1'b0;
    bus.mem_rsp_valid    = 1'b0;
    bus.mem_rsp_data     = '0;

    @(negedge clk);
    checkOutput("rst_fill_req_ready", vec_t'(bus.fill_req_ready), vec_t'(1));
    checkOutput("rst_mem_req_valid", vec_t'(bus.mem_req_valid), vec_t'(0));
    checkOutput("rst_mem_rsp_ready", vec_t'(bus.mem_rsp_ready), vec_t'(0));
    checkOutput("rst_update_en", vec_t'(bus.update_en), vec_t'(0));
    checkOutput("rst_fill_done_valid", vec_t'(bus.fill_done_valid), vec_t'(0));
    checkOutput("rst_update_data", bus.update_data, vec_t'(0));
    checkOutput("rst_mem_req_addr", vec_t'(bus.mem_req_addr), vec_t'(0));
    checkOutput("rst_update_idx", vec_t'({bus.update_set_idx, bus.update_way_idx}), vec_t'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] zero-wait fill");
    applyStimulus(32'h0000_1A40, 2, 0, 0, 1'b1, 1'b0, -1, 1'b1);
    idleBeats();

    $display("[TB] unaligned address");
    applyStimulus(32'h0000_1A7C, 1, 0, 0, 1'b0, 1'b0, -1, 1'b1);

    $display("[TB] stalled request and beat gaps");
    applyStimulus($urandom, int'($urandom_range(3, 0)), 5, 3, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] request held through a fill");
    applyStimulus($urandom, 3, 0, 1, 1'b0, 1'b1, -1, 1'b0);
    applyStimulus($urandom, 0, 0, 0, 1'b0, 1'b0, -1, 1'b1);

    $display("[TB] reset mid-fill");
    applyStimulus($urandom, 1, 0, 1, 1'b0, 1'b0, 7, 1'b0);
    idleBeats();
    applyStimulus($urandom, 2, 0, 0, 1'b0, 1'b0, -1, 1'b1);

    $display("[TB] random fills");
    for (int k = 0; k < 6; k++) begin
      applyStimulus($urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                    2, 1'b0, 1'b0, -1, 1'b0);
      if (k % 2 == 1) idleBeats();
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("pending_fills", vec_t'(sbQ.size()), vec_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
